control_stall_unit: RTL and testbench

- Central pipeline sequencer for the 5-stage RISC-V core with L1 I/D caches.
- Owns the write-enables and bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use hazards that the EX bypass network cannot cover, I-cache and D-cache miss stalls, and taken-branch redirects.
- Tracks a wrong-path fetch that is still outstanding in the I-cache, and counts stall and flush cycles.

---
 rtl/control_stall_unit_pkg.sv | 22 ++
 rtl/control_stall_unit_stall_perf_counter.sv | 29 ++
 rtl/control_stall_unit.sv | 157 +++++++++++++++
 tb/tb_control_stall_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_stall_unit_pkg.sv
// ---------------------------------------------------------------------------
// control_stall_unit_pkg
//   Shared definitions for the pipeline stall/flush sequencer:
//     - stall_state_e : sequencer state encoding (2 bits)
//     - NOP_INSTR     : instruction loaded into IF/ID when it is flushed
//     - CNT_W_DEFAULT : default width of the performance counters
// ---------------------------------------------------------------------------
package control_stall_unit_pkg;

   typedef enum logic [1:0] {
      STALL_RUN     = 2'd0,
      STALL_DSTALL  = 2'd1,
      STALL_ISTALL  = 2'd2,
      STALL_ISQUASH = 2'd3
   } stall_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/control_stall_unit_stall_perf_counter.sv
// ---------------------------------------------------------------------------
// stall_perf_counter
//   Saturating up-counter used for the sequencer performance counters.
//   Ports:
//     clock  - system clock, rising edge
//     reset  - asynchronous active-low reset, clears the count
//     inc    - add one this cycle (ignored once the count is all-ones)
//     count  - current count value
// ---------------------------------------------------------------------------
module stall_perf_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/control_stall_unit.sv
// ---------------------------------------------------------------------------
// control_stall_unit
//   Central sequencer for the 5-stage core. Drives the load enables and
//   bubble/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from the
//   hazard inputs, tracks a wrong-path fetch still outstanding in the
//   I-cache, and counts stall cycles and taken-branch redirects.
//   Event priority: D-miss > redirect > load-use > I-miss > normal.
//   Ports:
//     clock, reset            - rising-edge clock, async active-low reset
//     ifid_rs1/ifid_rs2       - source registers of the instruction in IF/ID
//     idex_rd, idex_memread   - destination / load flag of the ID/EX instr.
//     branch_taken            - branch/jump in EX resolved taken
//     exmem_memreq            - EX/MEM holds a load or store
//     dcache_ready            - D-cache completes the EX/MEM access
//     icache_ready            - I-cache returns a valid instruction
//     pc_write, pc_sel_branch - PC load enable / take branch target
//     ifid_write, ifid_flush  - IF/ID load enable / load NOP
//     idex_write, idex_bubble - ID/EX load enable / load NOP controls
//     exmem_write             - EX/MEM load enable
//     memwb_bubble            - load NOP controls into MEM/WB
//     stall_cycles            - saturating count of stalled cycles
//     flush_count             - saturating count of taken-branch redirects
// ---------------------------------------------------------------------------
module control_stall_unit
   import control_stall_unit_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic [4:0]       idex_rd,
   input  logic             idex_memread,
   input  logic             branch_taken,
   input  logic             exmem_memreq,
   input  logic             dcache_ready,
   input  logic             icache_ready,
   output logic             pc_write,
   output logic             pc_sel_branch,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             memwb_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   stall_state_e state, state_next;
   logic         squash_pending, squash_next;
   logic         dmiss, redirect, loaduse, imiss;
   logic         stall_inc, flush_inc;

   assign dmiss    = exmem_memreq & ~dcache_ready;
   assign redirect = branch_taken;
   assign loaduse  = idex_memread & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));
   assign imiss    = ~icache_ready;

   // A stall cycle is any cycle the front end loses: a D-miss, a load-use
   // or I-miss that is not overridden by a redirect (the redirect discards
   // that work anyway), or any cycle spent waiting out a wrong-path fetch.
   assign stall_inc = dmiss | (state == STALL_ISQUASH) |
                      (~redirect & (loaduse | imiss));
   assign flush_inc = ~dmiss & redirect;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= STALL_RUN;
         squash_pending <= 1'b0;
      end else begin
         state          <= state_next;
         squash_pending <= squash_next;
      end
   end

   // NOTE: every output and next-state variable gets a default at the top of
   // the block so no path through the if-chain can infer a latch.
   always_comb begin
      pc_write      = 1'b0;
      pc_sel_branch = 1'b0;
      ifid_write    = 1'b0;
      ifid_flush    = 1'b0;
      idex_write    = 1'b0;
      idex_bubble   = 1'b0;
      exmem_write   = 1'b0;
      memwb_bubble  = 1'b0;
      state_next    = state;
      squash_next   = squash_pending;

      // Controls are combinational, so they are forced idle while reset is
      // held rather than waiting for the state register to clear.
      if (reset) begin
         if (dmiss) begin
            // Freeze everything up to EX/MEM; a held branch acts on release.
            memwb_bubble = 1'b1;
            state_next   = STALL_DSTALL;
         end else if (redirect) begin
            pc_write      = 1'b1;
            pc_sel_branch = 1'b1;
            ifid_write    = 1'b1;
            ifid_flush    = 1'b1;
            idex_write    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_write   = 1'b1;
            // If the fetch still missing is from the old path, its eventual
            // return must be discarded. A fetch that completes this cycle is
            // already killed by ifid_flush.
            squash_next   = imiss;
            state_next    = imiss ? STALL_ISQUASH : STALL_RUN;
         end else if (loaduse) begin
            idex_write  = 1'b1;
            idex_bubble = 1'b1;
            exmem_write = 1'b1;
            state_next  = squash_pending ? STALL_ISQUASH : STALL_RUN;
         end else if (imiss) begin
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            state_next  = squash_pending ? STALL_ISQUASH : STALL_ISTALL;
         end else if (squash_pending) begin
            // The wrong-path instruction arrives now: drop it and move on.
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            squash_next = 1'b0;
            state_next  = STALL_RUN;
         end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            state_next  = STALL_RUN;
         end
      end
   end

   stall_perf_counter #(.W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   stall_perf_counter #(.W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_control_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_control_stall_unit
//   Directed stimulus with hand-computed expectations, plus a per-cycle
//   comparison of both DUT instances (default and 2-bit counters) against a
//   table-driven model of the sequencing rules.
// ---------------------------------------------------------------------------
module tb_control_stall_unit;

   logic       clock;
   logic       reset;
   logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
   logic       idex_memread, branch_taken, exmem_memreq;
   logic       dcache_ready, icache_ready;

   logic        pc_write, pc_sel_branch, ifid_write, ifid_flush;
   logic        idex_write, idex_bubble, exmem_write, memwb_bubble;
   logic [31:0] stall_cycles, flush_count;

   logic        s_pc_write, s_pc_sel_branch, s_ifid_write, s_ifid_flush;
   logic        s_idex_write, s_idex_bubble, s_exmem_write, s_memwb_bubble;
   logic [1:0]  s_stall_cycles, s_flush_count;

   int tests_run = 0;
   int tests_failed = 0;

   control_stall_unit dut (
      .clock(clock), .reset(reset),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
      .idex_memread(idex_memread), .branch_taken(branch_taken),
      .exmem_memreq(exmem_memreq), .dcache_ready(dcache_ready),
      .icache_ready(icache_ready),
      .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble),
      .exmem_write(exmem_write), .memwb_bubble(memwb_bubble),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   control_stall_unit #(.CNT_W(2)) dut_small (
      .clock(clock), .reset(reset),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
      .idex_memread(idex_memread), .branch_taken(branch_taken),
      .exmem_memreq(exmem_memreq), .dcache_ready(dcache_ready),
      .icache_ready(icache_ready),
      .pc_write(s_pc_write), .pc_sel_branch(s_pc_sel_branch),
      .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
      .idex_write(s_idex_write), .idex_bubble(s_idex_bubble),
      .exmem_write(s_exmem_write), .memwb_bubble(s_memwb_bubble),
      .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Control vector order:
   // {pc_write, pc_sel_branch, ifid_write, ifid_flush,
   //  idex_write, idex_bubble, exmem_write, memwb_bubble}
   localparam logic [7:0] C_DMISS   = 8'b0000_0001;
   localparam logic [7:0] C_REDIR   = 8'b1111_1110;
   localparam logic [7:0] C_LOADUSE = 8'b0000_1110;
   localparam logic [7:0] C_IMISS   = 8'b0011_1010;
   localparam logic [7:0] C_DROP    = 8'b1011_1010;
   localparam logic [7:0] C_NORMAL  = 8'b1010_1010;

   bit wrong_fetch_out;   // a wrong-path fetch is still owed by the I-cache
   bit waiting_squash;    // sequencer sits in its squash-wait state
   int m_stall, m_flush;

   typedef enum {EV_DMISS, EV_REDIR, EV_LOADUSE, EV_IMISS, EV_DROP, EV_NORMAL} ev_e;

   function automatic ev_e cur_event();
      if (exmem_memreq && !dcache_ready) return EV_DMISS;
      if (branch_taken) return EV_REDIR;
      if (idex_memread && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2))
         return EV_LOADUSE;
      if (!icache_ready) return EV_IMISS;
      if (wrong_fetch_out) return EV_DROP;
      return EV_NORMAL;
   endfunction

   function automatic logic [7:0] model_ctrl();
      if (!reset) return 8'h00;
      case (cur_event())
         EV_DMISS:   return C_DMISS;
         EV_REDIR:   return C_REDIR;
         EV_LOADUSE: return C_LOADUSE;
         EV_IMISS:   return C_IMISS;
         EV_DROP:    return C_DROP;
         default:    return C_NORMAL;
      endcase
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrong_fetch_out = 0;
         waiting_squash  = 0;
         m_stall         = 0;
         m_flush         = 0;
      end else begin
         ev_e ev;
         ev = cur_event();
         if (ev == EV_DMISS || waiting_squash || ev == EV_LOADUSE || ev == EV_IMISS)
            m_stall++;
         if (ev == EV_REDIR) m_flush++;
         case (ev)
            EV_DMISS:   waiting_squash = 0;
            EV_REDIR: begin
               wrong_fetch_out = !icache_ready;
               waiting_squash  = !icache_ready;
            end
            EV_LOADUSE, EV_IMISS: waiting_squash = wrong_fetch_out;
            EV_DROP: begin
               wrong_fetch_out = 0;
               waiting_squash  = 0;
            end
            default: waiting_squash = 0;
         endcase
      end
   end

   always @(negedge clock) begin
      logic [7:0] exp_c;
      exp_c = model_ctrl();
      check("ctrl", {pc_write, pc_sel_branch, ifid_write, ifid_flush,
                     idex_write, idex_bubble, exmem_write, memwb_bubble}, {24'd0, exp_c});
      check("ctrl_small", {s_pc_write, s_pc_sel_branch, s_ifid_write, s_ifid_flush,
                           s_idex_write, s_idex_bubble, s_exmem_write, s_memwb_bubble},
            {24'd0, exp_c});
      check("stall_cycles", stall_cycles, m_stall);
      check("flush_count", flush_count, m_flush);
      check("stall_small", {30'd0, s_stall_cycles}, (m_stall > 3) ? 3 : m_stall);
      check("flush_small", {30'd0, s_flush_count}, (m_flush > 3) ? 3 : m_flush);
   end

   // ---------------- directed stimulus ----------------
   task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic mq,
                         input logic dr, input logic ir);
      idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
      branch_taken = br; exmem_memreq = mq; dcache_ready = dr; icache_ready = ir;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      @(negedge clock);
      check("rst_pc_write", pc_write, 0);
      check("rst_ifid_write", ifid_write, 0);
      check("rst_stall", stall_cycles, 0);
      next_cycle();
      reset = 1'b1;

      // normal flow
      @(negedge clock);
      check("norm_pc_write", pc_write, 1);
      check("norm_exmem_write", exmem_write, 1);
      next_cycle();

      // load-use on rs2
      set_in(1, 5, 0, 5, 0, 0, 1, 1);
      @(negedge clock);
      check("lu_pc_write", pc_write, 0);
      check("lu_ifid_write", ifid_write, 0);
      check("lu_idex_bubble", idex_bubble, 1);
      next_cycle();
      idle();
      @(negedge clock);
      check("lu_after_pc_write", pc_write, 1);
      check("lu_stall", stall_cycles, 1);
      next_cycle();

      // load to x0 is never a hazard
      set_in(1, 0, 0, 7, 0, 0, 1, 1);
      @(negedge clock);
      check("x0_pc_write", pc_write, 1);
      check("x0_idex_bubble", idex_bubble, 0);
      next_cycle();

      // D-miss for 4 cycles with a branch held in EX
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 0, 1, 1, 0, 1);
         @(negedge clock);
         check("dm_memwb_bubble", memwb_bubble, 1);
         check("dm_pc_sel", pc_sel_branch, 0);
         check("dm_pc_write", pc_write, 0);
         next_cycle();
      end
      set_in(0, 0, 0, 0, 1, 1, 1, 1);
      @(negedge clock);
      check("dm_rel_pc_sel", pc_sel_branch, 1);
      check("dm_rel_ifid_flush", ifid_flush, 1);
      next_cycle();
      idle();
      @(negedge clock);
      check("dm_flush_count", flush_count, 1);
      check("dm_stall", stall_cycles, 5);
      next_cycle();

      // redirect while the I-cache is missing
      set_in(0, 0, 0, 0, 1, 0, 1, 0);
      @(negedge clock);
      check("rim_pc_sel", pc_sel_branch, 1);
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 1, 0);
         @(negedge clock);
         check("rim_wait_pc_write", pc_write, 0);
         check("rim_wait_flush", ifid_flush, 1);
         next_cycle();
      end
      idle();
      @(negedge clock);
      check("rim_drop_flush", ifid_flush, 1);
      check("rim_drop_pc_write", pc_write, 1);
      next_cycle();
      @(negedge clock);
      check("rim_run_flush", ifid_flush, 0);
      check("rim_stall", stall_cycles, 9);
      check("rim_flush_count", flush_count, 2);
      next_cycle();

      // branch and load-use together: redirect only
      set_in(1, 3, 3, 0, 1, 0, 1, 1);
      @(negedge clock);
      check("blu_pc_write", pc_write, 1);
      check("blu_pc_sel", pc_sel_branch, 1);
      check("blu_idex_bubble", idex_bubble, 1);
      check("blu_ifid_write", ifid_write, 1);
      next_cycle();
      idle();
      @(negedge clock);
      check("blu_stall", stall_cycles, 9);
      check("blu_flush_count", flush_count, 3);
      next_cycle();

      // plain I-miss for 2 cycles
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 1, 0);
         @(negedge clock);
         check("im_pc_write", pc_write, 0);
         check("im_flush", ifid_flush, 1);
         next_cycle();
      end
      idle();
      @(negedge clock);
      check("im_rel_flush", ifid_flush, 0);
      check("im_rel_pc_write", pc_write, 1);
      check("im_stall", stall_cycles, 11);
      check("sat_stall_small", {30'd0, s_stall_cycles}, 3);
      check("sat_flush_small_a", {30'd0, s_flush_count}, 3);
      next_cycle();

      // one more redirect: 2-bit counter must hold at all-ones
      set_in(0, 0, 0, 0, 1, 0, 1, 1);
      next_cycle();
      idle();
      @(negedge clock);
      check("sat_flush_small_b", {30'd0, s_flush_count}, 3);
      check("flush_count_4", flush_count, 4);
      next_cycle();

      // async reset while in a D-miss
      for (int i = 0; i < 2; i++) begin
         set_in(0, 0, 0, 0, 0, 1, 0, 1);
         @(negedge clock);
         check("rd_memwb_bubble", memwb_bubble, 1);
         if (i == 0) next_cycle();
      end
      #2 reset = 1'b0;
      #1;
      check("rd_memwb_zero", memwb_bubble, 0);
      check("rd_exmem_zero", exmem_write, 0);
      check("rd_stall_zero", stall_cycles, 0);
      check("rd_flush_zero", flush_count, 0);
      next_cycle();
      idle();
      reset = 1'b1;
      @(negedge clock);
      check("rd_after_pc_write", pc_write, 1);
      check("rd_after_memwb", memwb_bubble, 0);
      check("rd_after_stall", stall_cycles, 0);
      next_cycle();
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
